// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results that lose
// are queued in a small FIFO that is force-drained by a one-cycle writeback stall.
module regfile_wb_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset,
   input  logic                     i_RegWriteW,
   input  logic [4:0]               i_RdW,
   input  logic [31:0]              i_ResultW,
   input  logic                     i_MduValid,
   input  logic [4:0]               i_MduRd,
   input  logic [31:0]              i_MduData,
   output logic                     o_MduReady,
   output logic                     o_StallW,
   output logic                     o_WE3,
   output logic [4:0]               o_A3,
   output logic [31:0]              o_WD3,
   output logic [31:0]              o_PendingMask,
   output logic [$clog2(DEPTH):0]   o_Count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(MAX_WAIT + 1);

   typedef enum logic {NORMAL, DRAIN} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic [4:0]      rd_mem_q   [DEPTH];
   logic [31:0]     data_mem_q [DEPTH];

   logic            p_req;
   logic            m_req;
   logic            fifo_empty;
   logic            mdu_ready;
   logic            pipe_wr;
   logic            pop;
   logic            bypass;
   logic            push;
   logic            we3;
   logic [4:0]      a3;
   logic [31:0]     wd3;
   logic [31:0]     pending;
   logic [AW-1:0]   scan_idx;

   assign fifo_empty = (count_q == '0);
   assign mdu_ready  = (count_q < CW'(DEPTH));
   assign p_req      = i_RegWriteW & (i_RdW != 5'd0) & (state_q != DRAIN);
   assign m_req      = i_MduValid & (i_MduRd != 5'd0);

   // Pipeline first, then queued MDU results, then a direct MDU bypass; DRAIN hands the port to the head.
   always_comb begin
      pipe_wr = 1'b0;
      pop     = 1'b0;
      bypass  = 1'b0;
      if (state_q == DRAIN) begin
         pop = ~fifo_empty;
      end else if (p_req) begin
         pipe_wr = 1'b1;
      end else if (!fifo_empty) begin
         pop = 1'b1;
      end else if (m_req && mdu_ready) begin
         bypass = 1'b1;
      end
      push = m_req & mdu_ready & ~bypass;
   end

   always_comb begin
      we3 = 1'b0;
      a3  = 5'd0;
      wd3 = 32'd0;
      if (pipe_wr) begin
         we3 = 1'b1;
         a3  = i_RdW;
         wd3 = i_ResultW;
      end else if (pop) begin
         we3 = 1'b1;
         a3  = rd_mem_q[head_q];
         wd3 = data_mem_q[head_q];
      end else if (bypass) begin
         we3 = 1'b1;
         a3  = i_MduRd;
         wd3 = i_MduData;
      end
   end

   always_comb begin
      head_d  = pop  ? head_q + AW'(1) : head_q;
      tail_d  = push ? tail_q + AW'(1) : tail_q;
      count_d = count_q + CW'(push) - CW'(pop);

      wait_d = wait_q;
      if (pop || fifo_empty) begin
         wait_d = '0;
      end else if (state_q == NORMAL && wait_q != WW'(MAX_WAIT)) begin
         wait_d = wait_q + WW'(1);
      end

      state_d = state_q;
      if (state_q == DRAIN) begin
         state_d = NORMAL;
      end else if (wait_d == WW'(MAX_WAIT)) begin
         state_d = DRAIN;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q <= NORMAL;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         wait_q  <= (state_q == DRAIN) ? '0 : wait_d;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (push) begin
         rd_mem_q[tail_q]   <= i_MduRd;
         data_mem_q[tail_q] <= i_MduData;
      end
   end

   // The mask is rebuilt from the live FIFO entries, so duplicate destinations keep their bit until the last one retires.
   always_comb begin
      pending  = '0;
      scan_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head_q + AW'(i);
         if (CW'(i) < count_q) begin
            pending[rd_mem_q[scan_idx]] = 1'b1;
         end
      end
   end

   assign o_MduReady    = mdu_ready;
   assign o_StallW      = (state_q == DRAIN);
   assign o_WE3         = we3 & ~i_Reset;
   assign o_A3          = i_Reset ? 5'd0  : a3;
   assign o_WD3         = i_Reset ? 32'd0 : wd3;
   assign o_PendingMask = pending;
   assign o_Count       = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_regfile_wb_arbiter;

   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;
   localparam int CW       = $clog2(DEPTH) + 1;

   logic           i_Clk;
   logic           i_Reset;
   logic           reg_write_w;
   logic [4:0]     rd_w;
   logic [31:0]    result_w;
   logic           mdu_valid;
   logic [4:0]     mdu_rd;
   logic [31:0]    mdu_data;
   logic           o_MduReady;
   logic           o_StallW;
   logic           o_WE3;
   logic [4:0]     o_A3;
   logic [31:0]    o_WD3;
   logic [31:0]    o_PendingMask;
   logic [CW-1:0]  o_Count;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t mq[$];
   int   mwait;
   bit   mdrain;

   regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .i_Clk         (i_Clk),
      .i_Reset       (i_Reset),
      .i_RegWriteW   (reg_write_w),
      .i_RdW         (rd_w),
      .i_ResultW     (result_w),
      .i_MduValid    (mdu_valid),
      .i_MduRd       (mdu_rd),
      .i_MduData     (mdu_data),
      .o_MduReady    (o_MduReady),
      .o_StallW      (o_StallW),
      .o_WE3         (o_WE3),
      .o_A3          (o_A3),
      .o_WD3         (o_WD3),
      .o_PendingMask (o_PendingMask),
      .o_Count       (o_Count)
   );

   initial begin
      i_Clk = 1'b0;
      forever #5 i_Clk = ~i_Clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic set_in(input logic we, input logic [4:0] rd, input logic [31:0] res,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
      reg_write_w = we;
      rd_w        = rd;
      result_w    = res;
      mdu_valid   = mv;
      mdu_rd      = mrd;
      mdu_data    = md;
   endtask

   task automatic tick;
      @(posedge i_Clk);
      #1;
   endtask

   task automatic do_reset;
      i_Reset = 1'b1;
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      i_Reset = 1'b0;
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      m = '0;
      foreach (mq[i]) m[mq[i].rd] = 1'b1;
      return m;
   endfunction

   task automatic test_reset;
      logic [37:0] wr_exp;
      do_reset();
      #1;
      n_checks++;
      if ({o_Count, o_PendingMask, o_MduReady, o_StallW, o_WE3} !== {CW'(0), 32'd0, 1'b1, 1'b0, 1'b0})
         $display("[TB] FAIL reset_idle: got cnt=%0d mask=%h rdy=%b stall=%b we=%b expected 0/0/1/0/0",
                  o_Count, o_PendingMask, o_MduReady, o_StallW, o_WE3);
      else n_pass++;
      set_in(1'b1, 5'd1, 32'h11, 1'b1, 5'd5, 32'h55);
      tick();
      set_in(1'b1, 5'd2, 32'h22, 1'b1, 5'd7, 32'h77);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      n_checks++;
      if ({o_Count, o_PendingMask} !== {CW'(2), 32'h0000_00A0})
         $display("[TB] FAIL reset_preload: got cnt=%0d mask=%h expected cnt=2 mask=000000a0", o_Count, o_PendingMask);
      else n_pass++;
      i_Reset = 1'b1;
      #1;
      wr_exp = '0;
      n_checks++;
      if ({o_WE3, o_A3, o_WD3} !== wr_exp)
         $display("[TB] FAIL reset_write_gated: got %h expected %h", {o_WE3, o_A3, o_WD3}, wr_exp);
      else n_pass++;
      tick();
      i_Reset = 1'b0;
      #1;
      n_checks++;
      if ({o_Count, o_PendingMask, o_WE3, o_MduReady} !== {CW'(0), 32'd0, 1'b0, 1'b1})
         $display("[TB] FAIL reset_flush: got cnt=%0d mask=%h we=%b rdy=%b expected 0/0/0/1",
                  o_Count, o_PendingMask, o_WE3, o_MduReady);
      else n_pass++;
   endtask

   task automatic test_bypass;
      do_reset();
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h1234);
      #1;
      n_checks++;
      if ({o_WE3, o_A3, o_WD3} !== {1'b1, 5'd3, 32'h1234})
         $display("[TB] FAIL bypass_write: got we=%b a=%0d wd=%h expected 1/3/00001234", o_WE3, o_A3, o_WD3);
      else n_pass++;
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      n_checks++;
      if ({o_Count, o_PendingMask} !== {CW'(0), 32'd0})
         $display("[TB] FAIL bypass_no_enqueue: got cnt=%0d mask=%h expected 0/0", o_Count, o_PendingMask);
      else n_pass++;
   endtask

   task automatic test_collision;
      do_reset();
      set_in(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB);
      #1;
      n_checks++;
      if ({o_WE3, o_A3, o_WD3} !== {1'b1, 5'd1, 32'hA})
         $display("[TB] FAIL collision_pipe_wins: got we=%b a=%0d wd=%h expected 1/1/a", o_WE3, o_A3, o_WD3);
      else n_pass++;
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      n_checks++;
      if ({o_Count, o_PendingMask, o_WE3, o_A3, o_WD3} !== {CW'(1), 32'h4, 1'b1, 5'd2, 32'hB})
         $display("[TB] FAIL collision_drain: got cnt=%0d mask=%h we=%b a=%0d wd=%h expected 1/4/1/2/b",
                  o_Count, o_PendingMask, o_WE3, o_A3, o_WD3);
      else n_pass++;
      tick();
      #1;
      n_checks++;
      if ({o_Count, o_PendingMask, o_WE3} !== {CW'(0), 32'd0, 1'b0})
         $display("[TB] FAIL collision_empty: got cnt=%0d mask=%h we=%b expected 0/0/0", o_Count, o_PendingMask, o_WE3);
      else n_pass++;
   endtask

   task automatic test_starvation;
      do_reset();
      set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99);
      tick();
      for (int k = 1; k <= 6; k++) begin
         set_in(1'b1, 5'(k + 10), 32'(k), 1'b0, 5'd0, 32'd0);
         #1;
         if (k == 5) begin
            n_checks++;
            if ({o_StallW, o_WE3, o_A3, o_WD3} !== {1'b1, 1'b1, 5'd9, 32'h99})
               $display("[TB] FAIL starve_drain: got stall=%b we=%b a=%0d wd=%h expected 1/1/9/99",
                        o_StallW, o_WE3, o_A3, o_WD3);
            else n_pass++;
         end else begin
            n_checks++;
            if ({o_StallW, o_WE3, o_A3, o_WD3} !== {1'b0, 1'b1, 5'(k + 10), 32'(k)})
               $display("[TB] FAIL starve_pipe_%0d: got stall=%b we=%b a=%0d wd=%h expected 0/1/%0d/%h",
                        k, o_StallW, o_WE3, o_A3, o_WD3, k + 10, k);
            else n_pass++;
         end
         tick();
      end
      #1;
      n_checks++;
      if (o_Count !== CW'(0))
         $display("[TB] FAIL starve_empty: got cnt=%0d expected 0", o_Count);
      else n_pass++;
   endtask

   task automatic test_full;
      do_reset();
      set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'h100A);
      tick();
      set_in(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'h100B);
      tick();
      set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'h100C);
      #1;
      n_checks++;
      if ({o_MduReady, o_Count} !== {1'b0, CW'(2)})
         $display("[TB] FAIL full_not_ready: got rdy=%b cnt=%0d expected 0/2", o_MduReady, o_Count);
      else n_pass++;
      tick();
      tick();
      tick();
      #1;
      n_checks++;
      if ({o_StallW, o_MduReady, o_WE3, o_A3, o_WD3} !== {1'b1, 1'b0, 1'b1, 5'd10, 32'h100A})
         $display("[TB] FAIL full_drain: got stall=%b rdy=%b we=%b a=%0d wd=%h expected 1/0/1/10/100a",
                  o_StallW, o_MduReady, o_WE3, o_A3, o_WD3);
      else n_pass++;
      tick();
      #1;
      n_checks++;
      if ({o_StallW, o_MduReady, o_Count, o_WE3, o_A3} !== {1'b0, 1'b1, CW'(1), 1'b1, 5'd3})
         $display("[TB] FAIL full_after_drain: got stall=%b rdy=%b cnt=%0d we=%b a=%0d expected 0/1/1/1/3",
                  o_StallW, o_MduReady, o_Count, o_WE3, o_A3);
      else n_pass++;
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      n_checks++;
      if ({o_PendingMask, o_WE3, o_A3, o_WD3} !== {32'h0000_1800, 1'b1, 5'd11, 32'h100B})
         $display("[TB] FAIL full_order_1: got mask=%h we=%b a=%0d wd=%h expected 00001800/1/11/100b",
                  o_PendingMask, o_WE3, o_A3, o_WD3);
      else n_pass++;
      tick();
      #1;
      n_checks++;
      if ({o_PendingMask, o_WE3, o_A3, o_WD3} !== {32'h0000_1000, 1'b1, 5'd12, 32'h100C})
         $display("[TB] FAIL full_order_2: got mask=%h we=%b a=%0d wd=%h expected 00001000/1/12/100c",
                  o_PendingMask, o_WE3, o_A3, o_WD3);
      else n_pass++;
      tick();
   endtask

   task automatic test_rd0;
      do_reset();
      set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h44);
      tick();
      set_in(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
      #1;
      n_checks++;
      if ({o_WE3, o_A3, o_WD3} !== {1'b1, 5'd4, 32'h44})
         $display("[TB] FAIL rd0_pipe_yields: got we=%b a=%0d wd=%h expected 1/4/44", o_WE3, o_A3, o_WD3);
      else n_pass++;
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF);
      #1;
      n_checks++;
      if ({o_MduReady, o_WE3} !== {1'b1, 1'b0})
         $display("[TB] FAIL rd0_mdu_ack: got rdy=%b we=%b expected 1/0", o_MduReady, o_WE3);
      else n_pass++;
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      n_checks++;
      if ({o_Count, o_PendingMask} !== {CW'(0), 32'd0})
         $display("[TB] FAIL rd0_mdu_dropped: got cnt=%0d mask=%h expected 0/0", o_Count, o_PendingMask);
      else n_pass++;
   endtask

   task automatic test_random;
      bit          rst, we, mv, p, m, rdy, was_empty;
      logic [4:0]  rd, mrd;
      logic [31:0] res, md;
      int          kind;
      logic [37:0] e_wr;
      do_reset();
      mq.delete();
      mwait  = 0;
      mdrain = 0;
      for (int c = 0; c < 500; c++) begin
         rst = ($urandom_range(0, 79) == 0);
         we  = ($urandom_range(0, 9) < 7);
         mv  = ($urandom_range(0, 1) == 1);
         rd  = 5'($urandom_range(0, 9));
         mrd = 5'($urandom_range(0, 9));
         res = $urandom;
         md  = $urandom;
         i_Reset = rst;
         set_in(we, rd, res, mv, mrd, md);
         #1;
         p    = we && (rd != 0) && !mdrain;
         m    = mv && (mrd != 0);
         rdy  = (mq.size() < DEPTH);
         kind = 0;
         if (mdrain) kind = (mq.size() > 0) ? 2 : 0;
         else if (p) kind = 1;
         else if (mq.size() > 0) kind = 2;
         else if (m && rdy) kind = 3;
         case (kind)
            1:       e_wr = {1'b1, rd, res};
            2:       e_wr = {1'b1, mq[0].rd, mq[0].data};
            3:       e_wr = {1'b1, mrd, md};
            default: e_wr = '0;
         endcase
         if (rst) e_wr = '0;
         n_checks++;
         if ({o_WE3, o_A3, o_WD3} !== e_wr)
            $display("[TB] FAIL rand_write c=%0d: got %h expected %h", c, {o_WE3, o_A3, o_WD3}, e_wr);
         else n_pass++;
         n_checks++;
         if (o_StallW !== mdrain)
            $display("[TB] FAIL rand_stall c=%0d: got %b expected %b", c, o_StallW, mdrain);
         else n_pass++;
         n_checks++;
         if (o_MduReady !== rdy)
            $display("[TB] FAIL rand_ready c=%0d: got %b expected %b", c, o_MduReady, rdy);
         else n_pass++;
         n_checks++;
         if (o_Count !== CW'(mq.size()))
            $display("[TB] FAIL rand_count c=%0d: got %0d expected %0d", c, o_Count, mq.size());
         else n_pass++;
         n_checks++;
         if (o_PendingMask !== model_mask())
            $display("[TB] FAIL rand_mask c=%0d: got %h expected %h", c, o_PendingMask, model_mask());
         else n_pass++;
         @(posedge i_Clk);
         if (rst) begin
            mq.delete();
            mwait  = 0;
            mdrain = 0;
         end else begin
            was_empty = (mq.size() == 0);
            if (kind == 2) void'(mq.pop_front());
            if (m && rdy && kind != 3) mq.push_back('{rd: mrd, data: md});
            if (kind == 2 || was_empty) mwait = 0;
            else if (!mdrain && mwait < MAX_WAIT) mwait++;
            if (mdrain) begin
               mdrain = 0;
               mwait  = 0;
            end else begin
               mdrain = (mwait == MAX_WAIT);
            end
         end
         #1;
      end
      i_Reset = 1'b0;
   endtask

   initial begin
      i_Reset = 1'b1;
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      test_reset();
      test_bypass();
      test_collision();
      test_starvation();
      test_full();
      test_rd0();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the single register-file write port (A3/WD3/WE3) between two requesters: the pipeline writeback result and a multi-cycle unit (MDU: mul/div) that retires results out of order with the pipeline.
- MDU results that lose arbitration are buffered in a small FIFO. A starvation counter forces a one-cycle writeback stall to drain the buffer.
- Exports a pending-destination mask so the hazard unit can stall readers and writers of registers with queued MDU writes.
- Sits between the writeback stage mux, the MDU and the register file.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- MAX_WAIT, 4, cycles the FIFO head may wait before a forced drain (≥1)

Ports:
- i_Clk  in  1  clock
- i_Reset  in  1  synchronous, active-high reset
- i_RegWriteW  in  1  pipeline writeback write enable
- i_RdW  in  5  pipeline destination register
- i_ResultW  in  32  pipeline writeback data
- i_MduValid  in  1  MDU result valid
- i_MduRd  in  5  MDU destination register
- i_MduData  in  32  MDU result data
- o_MduReady  out  1  FIFO can accept an MDU result
- o_StallW  out  1  registered; pipeline must hold its W-stage register this cycle
- o_WE3  out  1  register-file write enable
- o_A3  out  5  register-file write address
- o_WD3  out  32  register-file write data
- o_PendingMask  out  32  bit r set while an MDU write to xr is accepted but not yet written
- o_Count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: single clock i_Clk. Reset is synchronous and active-high on i_Reset.
- Reset values: FIFO empty, o_Count=0, wait counter=0, state=NORMAL, o_StallW=0, o_PendingMask=0, o_MduReady=1. o_WE3/o_A3/o_WD3=0 while i_Reset=1. Reset mid-operation discards all queued entries; their writes are lost.
- Pipeline request: PReq = i_RegWriteW & (i_RdW!=0) & ~o_StallW.
- MDU request: MReq = i_MduValid & (i_MduRd!=0). An MDU result with rd=0 is acknowledged (i_MduValid & o_MduReady), then dropped; no enqueue, no write.
- o_MduReady = (o_Count<DEPTH), combinational from registered state only; no dependence on dequeue in the same cycle.
- Write-port grant is combinational, same cycle (zero latency):
  - State NORMAL: PReq → pipeline writes. Else FIFO non-empty → head writes and is dequeued. Else MReq & o_MduReady → bypass, MDU data written directly, no enqueue. Else o_WE3=0.
  - State DRAIN: o_StallW=1, the pipeline write is ignored, the FIFO head writes. The held pipeline instruction is presented again in the next cycle.
- Enqueue: MReq & o_MduReady and the MDU result is not bypassed → push at the tail. Push and pop may occur in the same cycle; occupancy is unchanged and order is preserved (strict FIFO).
- Wait counter:
  - Increments when the FIFO is non-empty in NORMAL and the head is not written.
  - Clears on any dequeue or when the FIFO is empty.
  - Saturates at MAX_WAIT.
- State machine (NORMAL/DRAIN):
  - NORMAL→DRAIN at the clock edge where the counter's next value = MAX_WAIT.
  - DRAIN→NORMAL after exactly one cycle. The counter is cleared on exit.
  - o_StallW = (state==DRAIN).
- o_PendingMask:
  - Bit set on enqueue.
  - Bit cleared when that entry is written.
  - On set and clear of the same bit in one cycle, the set wins if another queued entry still targets that rd (per-register counters or a FIFO scan; implementer's choice).
- No reordering or merging. The hazard unit guarantees, via o_PendingMask, that no pipeline write targets a pending rd. The block does not detect violations.

Test Plan:
- Reset with 2 entries queued (rd=5,7), o_PendingMask=0x000000A0 → next cycle o_Count=0, o_PendingMask=0, o_WE3=0, o_MduReady=1.
- Bypass: FIFO empty, i_RegWriteW=0, MDU valid rd=3 data=0x1234 → same cycle o_WE3=1, o_A3=3, o_WD3=0x1234, o_Count stays 0.
- Collision: pipeline rd=1 data=0xA and MDU rd=2 data=0xB in the same cycle → pipeline written, o_Count=1, mask bit2=1. Next idle cycle writes x2=0xB, mask=0.
- Starvation: one queued entry, pipeline writes every cycle, MAX_WAIT=4 → after 4 waiting cycles o_StallW=1 for exactly 1 cycle, head written, then NORMAL.
- Full: DEPTH=2, two entries queued, pipeline busy → o_MduReady=0, MDU held. After one drain, o_MduReady=1.
- rd=0: pipeline rd=0 with an MDU entry queued → MDU head written. MDU rd=0 → acknowledged, no write, no enqueue.
